// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Purpose : Shared definitions for the instruction fetch stage and the
//           decoder: default widths, reset PC, fetch FSM encoding and the
//           control opcodes that decode turns into halt/soft-reset commands.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int unsigned PC_W_DEF     = 16;
  localparam int unsigned INSTR_W      = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  // Control-class instructions: opcode nibble F, low 12 bits select the command
  localparam logic [3:0]  OPC_CONTROL  = 4'hF;
  localparam logic [11:0] CTRL_HALT    = 12'hFFF;
  localparam logic [11:0] CTRL_RESET   = 12'hAAA;

  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Purpose : Bundles the fetch stage's instruction-memory port, the decode
//           handshake and the control feedback (redirect/halt/soft reset).
// Modports: master - the fetch stage (drives *_po, samples *_pi)
//           slave  - memory/decoder/execute side (the opposite direction)
// ---------------------------------------------------------------------------
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_W_DEF
) ();

  logic                imem_req_po;
  logic [PC_WIDTH-1:0] imem_addr_po;
  logic                imem_valid_pi;
  logic [INSTR_W-1:0]  imem_rdata_pi;
  logic                instr_valid_po;
  logic [INSTR_W-1:0]  instruction_po;
  logic [PC_WIDTH-1:0] instr_pc_po;
  logic                instr_ready_pi;
  logic                redirect_pi;
  logic [PC_WIDTH-1:0] redirect_target_pi;
  logic                halt_pi;
  logic                soft_rst_pi;
  logic                halted_po;

  modport master (
    output imem_req_po, imem_addr_po, instr_valid_po, instruction_po,
           instr_pc_po, halted_po,
    input  imem_valid_pi, imem_rdata_pi, instr_ready_pi, redirect_pi,
           redirect_target_pi, halt_pi, soft_rst_pi
  );

  modport slave (
    input  imem_req_po, imem_addr_po, instr_valid_po, instruction_po,
           instr_pc_po, halted_po,
    output imem_valid_pi, imem_rdata_pi, instr_ready_pi, redirect_pi,
           redirect_target_pi, halt_pi, soft_rst_pi
  );

endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Purpose : Fetch stage. Holds the PC, issues one outstanding read at a time
//           to instruction memory and presents each fetched word to decode
//           with a valid/ready handshake. Handles redirect, halt and soft
//           reset; a read left in flight by those is dropped via a squash
//           flag when its response eventually arrives.
// Ports   : clk_pi   - clock, rising edge
//           rst_n_pi - synchronous active-low reset
//           fe_if    - instr_fetch_if.master (memory, decode, control)
// ---------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = PC_W_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic           clk_pi,
  input  logic           rst_n_pi,
  instr_fetch_if.master  fe_if
);

  fetch_state_e        r_state,  w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc,     w_pc_nxt;
  logic                r_squash, w_squash_nxt;
  logic                r_valid,  w_valid_nxt;
  logic [INSTR_W-1:0]  r_instr,  w_instr_nxt;
  logic [PC_WIDTH-1:0] r_ipc,    w_ipc_nxt;
  logic                r_halted, w_halted_nxt;
  logic                w_req;
  logic                w_squash_pend;

  // A request goes out only from ISSUE, with nothing stale in flight and no
  // control command overriding normal flow this cycle.
  assign w_req = rst_n_pi & (r_state == ST_ISSUE) & ~r_squash &
                 ~fe_if.soft_rst_pi & ~fe_if.redirect_pi & ~fe_if.halt_pi;

  // A read is still in flight (fresh in WAIT, or already squashed) and its
  // response has not arrived this cycle: it must be dropped later.
  assign w_squash_pend = ((r_state == ST_WAIT) | r_squash) & ~fe_if.imem_valid_pi;

  assign fe_if.imem_req_po    = w_req;
  assign fe_if.imem_addr_po   = r_pc;
  assign fe_if.instr_valid_po = r_valid;
  assign fe_if.instruction_po = r_instr;
  assign fe_if.instr_pc_po    = r_ipc;
  assign fe_if.halted_po      = r_halted;

  // Next-state / next-output logic, commands in priority order soft reset,
  // redirect, halt, then normal FSM flow.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_squash_nxt = r_squash & ~fe_if.imem_valid_pi;  // any response clears squash
    w_valid_nxt  = r_valid;
    w_instr_nxt  = r_instr;
    w_ipc_nxt    = r_ipc;
    w_halted_nxt = r_halted;

    if (fe_if.soft_rst_pi) begin
      w_state_nxt  = ST_ISSUE;
      w_pc_nxt     = RESET_PC;
      w_squash_nxt = w_squash_pend;
      w_valid_nxt  = 1'b0;
      w_instr_nxt  = '0;
      w_ipc_nxt    = '0;
      w_halted_nxt = 1'b0;
    end else if (fe_if.redirect_pi && (r_state != ST_HALTED)) begin
      // Also covers redirect racing ready in HOLD: the instruction counts as taken.
      w_state_nxt  = ST_ISSUE;
      w_pc_nxt     = fe_if.redirect_target_pi;
      w_squash_nxt = w_squash_pend;
      w_valid_nxt  = 1'b0;
    end else if (fe_if.halt_pi && (r_state != ST_HALTED)) begin
      w_state_nxt  = ST_HALTED;
      w_squash_nxt = w_squash_pend;
      w_valid_nxt  = 1'b0;
      w_halted_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_req) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (fe_if.imem_valid_pi) begin
            w_instr_nxt = fe_if.imem_rdata_pi;
            w_ipc_nxt   = r_pc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = r_pc + PC_WIDTH'(1);
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (fe_if.instr_ready_pi) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HALTED: begin
          w_state_nxt = ST_HALTED;
        end
        default: begin
          w_state_nxt = ST_ISSUE;
        end
      endcase
    end
  end

  // State and output holding registers with synchronous active-low reset.
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      r_state  <= ST_ISSUE;
      r_pc     <= RESET_PC;
      r_squash <= 1'b0;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_ipc    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_squash <= w_squash_nxt;
      r_valid  <= w_valid_nxt;
      r_instr  <= w_instr_nxt;
      r_ipc    <= w_ipc_nxt;
      r_halted <= w_halted_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Purpose : Directed test of instr_fetch. A behavioural memory returns
//           16'h1000 + address a programmable number of cycles after each
//           request; expected values are worked out by hand per step.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  int          mem_lat;
  bit          mem_pend;
  int          mem_cnt;
  logic [15:0] mem_addr;
  int          req_cnt;
  int          base;

  always #5 clk = ~clk;

  instr_fetch_if #(.PC_WIDTH(16)) ifc ();

  instr_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk_pi   (clk),
    .rst_n_pi (rst_n),
    .fe_if    (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records this cycle's request, advances one clock, then drives the
  // memory response for the new cycle.
  task automatic tick();
    #1;
    if (ifc.imem_req_po === 1'b1) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = ifc.imem_addr_po;
      req_cnt++;
    end
    @(posedge clk);
    #1;
    ifc.imem_valid_pi = 1'b0;
    ifc.imem_rdata_pi = 16'h0000;
    if (mem_pend) begin
      if (mem_cnt == 1) begin
        ifc.imem_valid_pi = 1'b1;
        ifc.imem_rdata_pi = 16'h1000 + mem_addr;
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.imem_valid_pi = 1'b0;
    ifc.imem_rdata_pi = 16'h0000;
    ifc.instr_ready_pi = 1'b1;
    ifc.redirect_pi = 1'b0;
    ifc.redirect_target_pi = 16'h0000;
    ifc.halt_pi = 1'b0;
    ifc.soft_rst_pi = 1'b0;
    mem_lat = 1; mem_pend = 1'b0; mem_cnt = 0; mem_addr = 16'h0000; req_cnt = 0;

    // reset state
    tick(); tick();
    #1;
    chk("rst_req", 32'(ifc.imem_req_po), 32'd0);
    chk("rst_valid", 32'(ifc.instr_valid_po), 32'd0);
    chk("rst_instr", 32'(ifc.instruction_po), 32'd0);
    chk("rst_ipc", 32'(ifc.instr_pc_po), 32'd0);
    chk("rst_halted", 32'(ifc.halted_po), 32'd0);
    rst_n = 1'b1;

    // streaming at latency 1, one instruction per 3 cycles
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t1_req", 32'(ifc.imem_req_po), 32'd1);
      chk("t1_addr", 32'(ifc.imem_addr_po), 32'(k));
      chk("t1_vld_issue", 32'(ifc.instr_valid_po), 32'd0);
      tick();
      #1;
      chk("t1_req_wait", 32'(ifc.imem_req_po), 32'd0);
      tick();
      #1;
      chk("t1_vld", 32'(ifc.instr_valid_po), 32'd1);
      chk("t1_instr", 32'(ifc.instruction_po), 32'(16'h1000 + k));
      chk("t1_pc", 32'(ifc.instr_pc_po), 32'(k));
      chk("t1_req_hold", 32'(ifc.imem_req_po), 32'd0);
      tick();
    end

    // decoder stall for 5 cycles
    ifc.instr_ready_pi = 1'b0;
    #1;
    chk("t2_addr", 32'(ifc.imem_addr_po), 32'h3);
    chk("t2_req", 32'(ifc.imem_req_po), 32'd1);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_vld", 32'(ifc.instr_valid_po), 32'd1);
      chk("t2_instr", 32'(ifc.instruction_po), 32'h1003);
      chk("t2_pc", 32'(ifc.instr_pc_po), 32'h3);
      chk("t2_noreq", 32'(ifc.imem_req_po), 32'd0);
      tick();
    end
    ifc.instr_ready_pi = 1'b1;
    #1;
    chk("t2_vld_acc", 32'(ifc.instr_valid_po), 32'd1);
    tick();
    #1;
    chk("t2_req_next", 32'(ifc.imem_req_po), 32'd1);
    chk("t2_addr_next", 32'(ifc.imem_addr_po), 32'h4);

    // redirect while in WAIT, latency 3: stale response squashed
    mem_lat = 3;
    tick();
    ifc.redirect_pi = 1'b1;
    ifc.redirect_target_pi = 16'h0040;
    #1;
    chk("t3_req_redir", 32'(ifc.imem_req_po), 32'd0);
    tick();
    ifc.redirect_pi = 1'b0;
    ifc.redirect_target_pi = 16'h0000;
    #1;
    chk("t3_squash1", 32'(ifc.imem_req_po), 32'd0);
    chk("t3_vld", 32'(ifc.instr_valid_po), 32'd0);
    tick();
    #1;
    chk("t3_squash2", 32'(ifc.imem_req_po), 32'd0);
    tick();
    #1;
    chk("t3_req", 32'(ifc.imem_req_po), 32'd1);
    chk("t3_addr", 32'(ifc.imem_addr_po), 32'h40);
    tick(); tick(); tick(); tick();
    #1;
    chk("t3_vld_new", 32'(ifc.instr_valid_po), 32'd1);
    chk("t3_instr", 32'(ifc.instruction_po), 32'h1040);
    chk("t3_pc", 32'(ifc.instr_pc_po), 32'h40);

    // redirect coinciding with the memory response
    mem_lat = 1;
    tick();
    #1;
    chk("t4_req", 32'(ifc.imem_req_po), 32'd1);
    chk("t4_addr", 32'(ifc.imem_addr_po), 32'h41);
    tick();
    ifc.redirect_pi = 1'b1;
    ifc.redirect_target_pi = 16'h0080;
    tick();
    ifc.redirect_pi = 1'b0;
    #1;
    chk("t4_nostall_req", 32'(ifc.imem_req_po), 32'd1);
    chk("t4_nostall_addr", 32'(ifc.imem_addr_po), 32'h80);
    chk("t4_vld", 32'(ifc.instr_valid_po), 32'd0);
    ifc.instr_ready_pi = 1'b0;
    tick(); tick();
    #1;
    chk("t4_instr", 32'(ifc.instruction_po), 32'h1080);
    chk("t4_pc", 32'(ifc.instr_pc_po), 32'h80);

    // halt, redirect ignored while halted, soft reset restarts
    ifc.halt_pi = 1'b1;
    tick();
    ifc.halt_pi = 1'b0;
    #1;
    chk("t5_halted", 32'(ifc.halted_po), 32'd1);
    chk("t5_vld", 32'(ifc.instr_valid_po), 32'd0);
    chk("t5_req", 32'(ifc.imem_req_po), 32'd0);
    ifc.redirect_pi = 1'b1;
    ifc.redirect_target_pi = 16'h0055;
    base = req_cnt;
    for (int k = 0; k < 20; k++) tick();
    #1;
    chk("t5_noreqs", 32'(req_cnt - base), 32'd0);
    chk("t5_still_halted", 32'(ifc.halted_po), 32'd1);
    ifc.redirect_pi = 1'b0;
    ifc.soft_rst_pi = 1'b1;
    #1;
    chk("t5_req_srst", 32'(ifc.imem_req_po), 32'd0);
    tick();
    ifc.soft_rst_pi = 1'b0;
    #1;
    chk("t5_unhalted", 32'(ifc.halted_po), 32'd0);
    chk("t5_req_after", 32'(ifc.imem_req_po), 32'd1);
    chk("t5_addr_after", 32'(ifc.imem_addr_po), 32'h0);

    // PC wrap at 16'hFFFF
    ifc.instr_ready_pi = 1'b1;
    ifc.redirect_pi = 1'b1;
    ifc.redirect_target_pi = 16'hFFFF;
    #1;
    chk("t6_req_redir", 32'(ifc.imem_req_po), 32'd0);
    tick();
    ifc.redirect_pi = 1'b0;
    #1;
    chk("t6_addr_ffff", 32'(ifc.imem_addr_po), 32'hFFFF);
    tick(); tick();
    #1;
    chk("t6_vld", 32'(ifc.instr_valid_po), 32'd1);
    chk("t6_pc", 32'(ifc.instr_pc_po), 32'hFFFF);
    chk("t6_instr", 32'(ifc.instruction_po), 32'h0FFF);
    tick();
    #1;
    chk("t6_wrap_req", 32'(ifc.imem_req_po), 32'd1);
    chk("t6_wrap_addr", 32'(ifc.imem_addr_po), 32'h0);

    // hardware reset in the middle of a latency-3 read
    tick(); tick(); tick();
    #1;
    chk("t7_addr1", 32'(ifc.imem_addr_po), 32'h1);
    mem_lat = 3;
    tick();
    rst_n = 1'b0;
    tick();
    #1;
    chk("t7_rst_vld", 32'(ifc.instr_valid_po), 32'd0);
    chk("t7_rst_instr", 32'(ifc.instruction_po), 32'd0);
    chk("t7_rst_pc", 32'(ifc.instr_pc_po), 32'd0);
    chk("t7_rst_halted", 32'(ifc.halted_po), 32'd0);
    chk("t7_rst_req", 32'(ifc.imem_req_po), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("t7_req", 32'(ifc.imem_req_po), 32'd1);
    chk("t7_addr", 32'(ifc.imem_addr_po), 32'h0);
    tick(); tick(); tick(); tick();
    #1;
    chk("t7_vld", 32'(ifc.instr_valid_po), 32'd1);
    chk("t7_instr", 32'(ifc.instruction_po), 32'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
